// File: rtl/rd_stream.sv
// rd_stream: memory read-stream engine.
// A launch reads `length` consecutive words starting at `base_addr`. The read
// is split into bursts of at most MAX_BURST beats, with at most one burst in
// flight. Returned beats go through a first-word-fall-through FIFO and are
// presented to the consumer as a valid/ready stream.
// Optional feature macro: RD_STREAM_PERF_EN enables the start-to-done cycle
// counter on event_counter_valid/event_counter_value. Without it those ports
// are tied to zero.

module rd_stream #(
    parameter int MEM_LEN_BITS   = 8,
    parameter int MEM_ADDR_BITS  = 32,
    parameter int MEM_DATA_BITS  = 64,
    parameter int HOST_DATA_BITS = 32,
    parameter int MAX_BURST      = 16,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [HOST_DATA_BITS-1:0] length,
    input  logic [MEM_ADDR_BITS-1:0]  base_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_req_valid,
    output logic                      mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]   mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    input  logic                      mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
    output logic                      mem_rd_ready,
    output logic                      out_valid,
    output logic [MEM_DATA_BITS-1:0]  out_data,
    input  logic                      out_ready,
    output logic                      event_counter_valid,
    output logic [HOST_DATA_BITS-1:0] event_counter_value
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [MEM_ADDR_BITS-1:0] BEAT_BYTES = MEM_ADDR_BITS'(MEM_DATA_BITS / 8);
    localparam logic [CNT_W-1:0]         DEPTH_C    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [MEM_ADDR_BITS-1:0]  addr_reg;
    logic [HOST_DATA_BITS-1:0] remaining_reg;
    logic [BURST_W-1:0]        burst_reg;
    logic [BURST_W-1:0]        beat_cnt_reg;
    logic                      done_reg;

    logic [MEM_DATA_BITS-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          rd_ptr_reg;
    logic [CNT_W-1:0]          count_reg, count_next;

    logic               start_accept;
    logic               launch;
    logic               empty_start;
    logic [BURST_W-1:0] burst_calc;
    logic [CNT_W-1:0]   free_space;
    logic               issue;
    logic               finish;
    logic               push;
    logic               pop;
    logic               last_beat;

    assign start_accept = (state_reg == IDLE) && start;
    assign launch       = start_accept && (length != '0);
    assign empty_start  = start_accept && (length == '0);

    // Size of the next burst: whatever is left, capped at MAX_BURST.
    assign burst_calc = (remaining_reg > HOST_DATA_BITS'(MAX_BURST)) ?
                        BURST_W'(MAX_BURST) : BURST_W'(remaining_reg);

    // Free space comes from registered occupancy only, so out_ready never
    // reaches the request path combinationally.
    assign free_space = DEPTH_C - count_reg;

    assign mem_rd_ready = (state_reg == WAIT);
    assign push         = mem_rd_valid && mem_rd_ready;
    assign out_valid    = (count_reg != '0);
    assign pop          = out_valid && out_ready;
    assign last_beat    = push && (beat_cnt_reg == BURST_W'(1));

    assign mem_req_valid  = issue;
    assign mem_req_opcode = 1'b0;
    assign mem_req_len    = issue ? MEM_LEN_BITS'(burst_calc - BURST_W'(1)) : '0;
    assign mem_req_addr   = issue ? addr_reg : '0;

    assign busy = (state_reg != IDLE);
    assign done = done_reg;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus the request/finish strobes of the current state.
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (free_space >= CNT_W'(burst_calc)) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (last_beat) begin
                    state_next = (remaining_reg == HOST_DATA_BITS'(burst_reg)) ? DRAIN : REQ;
                end
            end
            DRAIN: begin
                // Finish as soon as the FIFO is (about to be) empty so done
                // lands the cycle after the last pop.
                if (count_next == '0) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Transfer bookkeeping: address, remaining beats, current burst progress, done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            burst_reg     <= '0;
            beat_cnt_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            if (launch) begin
                addr_reg      <= base_addr;
                remaining_reg <= length;
            end
            if (issue) begin
                burst_reg    <= burst_calc;
                beat_cnt_reg <= burst_calc;
            end
            if (push) begin
                beat_cnt_reg <= beat_cnt_reg - BURST_W'(1);
                if (last_beat) begin
                    addr_reg      <= addr_reg + MEM_ADDR_BITS'(burst_reg) * BEAT_BYTES;
                    remaining_reg <= remaining_reg - HOST_DATA_BITS'(burst_reg);
                end
            end
            done_reg <= finish || empty_start;
        end
    end

    // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // FIFO pointers and occupancy; reset flushes the buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // FIFO storage; the head is read directly so the first word falls through.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= mem_rd_bits;
        end
    end

    assign out_data = out_valid ? fifo_mem[rd_ptr_reg] : '0;

`ifdef RD_STREAM_PERF_EN
    logic [HOST_DATA_BITS-1:0] perf_cnt_reg;
    logic                      perf_valid_reg;

    // Busy-cycle counter: cleared by an accepted start, saturates at all ones,
    // and holds its value after done until the next start.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cnt_reg   <= '0;
            perf_valid_reg <= 1'b0;
        end else begin
            if (start_accept) begin
                perf_cnt_reg <= '0;
            end else if (busy && (perf_cnt_reg != '1)) begin
                perf_cnt_reg <= perf_cnt_reg + HOST_DATA_BITS'(1);
            end
            perf_valid_reg <= finish || empty_start;
        end
    end

    assign event_counter_valid = perf_valid_reg;
    assign event_counter_value = perf_cnt_reg;
`else
    assign event_counter_valid = 1'b0;
    assign event_counter_value = '0;
`endif

endmodule

// File: doc/rd_stream.md
# rd_stream

Memory read-stream engine for the adder accelerator datapath. On a launch pulse it reads `length` consecutive MEM_DATA_BITS words from `base_addr` and splits the read into bursts of at most MAX_BURST beats on the MemDPI request/read channels. Returned beats are buffered in a local FIFO and presented as a valid/ready stream to the adder's operand input. One instance per operand stream (a, b) sits between the MemDPI read port and the adder.

## Interface
- MEM_LEN_BITS, 8, burst length field width
- MEM_ADDR_BITS, 32, byte address width
- MEM_DATA_BITS, 64, beat width; multiple of 8
- HOST_DATA_BITS, 32, width of `length` and event counter
- MAX_BURST, 16, max beats per burst; ≤ FIFO_DEPTH and ≤ 2^MEM_LEN_BITS
- FIFO_DEPTH, 32, buffer entries; power of two
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle launch pulse
- length  in  HOST_DATA_BITS  beats to read; sampled on start
- base_addr  in  MEM_ADDR_BITS  byte start address; sampled on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- mem_req_valid  out  1  read request; accepted in the cycle it is high (no backpressure)
- mem_req_opcode  out  1  always 0 (read)
- mem_req_len  out  MEM_LEN_BITS  beats-1 of the burst
- mem_req_addr  out  MEM_ADDR_BITS  burst byte address
- mem_rd_valid  in  1  read beat valid
- mem_rd_bits  in  MEM_DATA_BITS  read beat data
- mem_rd_ready  out  1  beat accepted when valid&&ready
- out_valid  out  1  stream word valid
- out_data  out  MEM_DATA_BITS  stream word
- out_ready  in  1  consumer accepts when valid&&ready
- event_counter_valid  out  1  cycle count valid pulse
- event_counter_value  out  HOST_DATA_BITS  cycles from start to done

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: start with length≠0 → latch addr/remaining, go to REQ. Start with length==0 → done pulse next cycle, stay IDLE. Start is ignored outside IDLE.
- REQ: burst = min(remaining, MAX_BURST). Issue only when FIFO free entries (DEPTH − occupancy) ≥ burst. Drive mem_req_valid for exactly 1 cycle with len=burst−1 and the current addr, then go to WAIT. Otherwise hold in REQ with mem_req_valid low.
- WAIT: mem_rd_ready=1. Each accepted beat is pushed to the FIFO and decrements the beat count. On the last beat of the burst: addr += burst·MEM_DATA_BITS/8 (mod 2^MEM_ADDR_BITS) and remaining −= burst; go to REQ if remaining>0, else DRAIN.
- DRAIN: when the FIFO is empty → done pulse, go to IDLE.
- At most one burst is outstanding. The free-space check guarantees no overflow.
- mem_rd_ready is 0 outside WAIT. Beats arriving then are dropped.
- The FIFO is first-word-fall-through. out_valid = !empty. Pop when out_valid&&out_ready.

## Timing
- Reset: state=IDLE, FIFO empty. busy, done, mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr, mem_rd_ready, out_valid, out_data, event_counter_valid and event_counter_value are all 0.
- start at cycle T → earliest mem_req_valid at T+1.
- Beat accepted at cycle N → visible on out_valid/out_data at N+1.
- Last pop at cycle N → done at N+1. busy falls in the same cycle done is high.
- No combinational path from out_ready to mem_rd_ready or mem_req_valid. Free space is computed from registered occupancy, so a pop in the same cycle is credited the following cycle.
- Simultaneous push and pop: occupancy is unchanged.
- Reset mid-operation: return to reset state next cycle and flush the FIFO. Late memory beats are ignored.

## Configuration
- RD_STREAM_PERF_EN defined:
  - A HOST_DATA_BITS counter clears on accepted start and increments every cycle while busy (saturating).
  - event_counter_valid pulses together with done; event_counter_value holds the count until the next start.
- RD_STREAM_PERF_EN undefined: event_counter_valid and event_counter_value are tied 0. Ports remain for a stable instantiation.

## Test plan
- length=1, base_addr=0x100, out_ready=1 → one request len=0 addr=0x100; one word out; done pulse; no further mem_req_valid.
- length=40, MAX_BURST=16, base_addr=0x1000, 64-bit beats → requests (addr, len) = (0x1000, 15), (0x1080, 15), (0x1100, 7); 40 words out in order; done once.
- length=64, out_ready=0 throughout → FIFO fills to 32, third request withheld; release out_ready → remaining bursts issue, all 64 words delivered in order.
- length=0 → done pulse at T+1, busy never high, no memory request.
- Reset asserted during WAIT with 5 beats pending → all outputs 0 next cycle, out_valid=0, subsequent mem_rd_valid beats ignored; fresh start of length=3 completes normally.
- RD_STREAM_PERF_EN with length=16, out_ready=1, 2-cycle memory latency → event_counter_valid coincides with done and value equals the measured start-to-done cycle count.
